// File: rtl/song_player_ctrl.sv
// Song playback controller: tempo beat enables, debounced tempo/pause button,
// one-hot song selection with restart pulse, and registered buzzer drive.
module song_player_ctrl #(
    parameter int unsigned CLK_HZ          = 5000000,
    parameter int unsigned NUM_SONGS       = 3,
    parameter int unsigned TEMPO0_HZ       = 4,
    parameter int unsigned TEMPO1_HZ       = 5,
    parameter int unsigned TEMPO2_HZ       = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic                         clk_5MHz,
    input  logic                         rst_n,
    input  logic [NUM_SONGS-1:0]         key,
    input  logic                         select,
    input  logic [NUM_SONGS-1:0]         song_beep,
    output logic                         beat_tick,
    output logic                         song_restart,
    output logic [$clog2(NUM_SONGS):0]   active_song,
    output logic [1:0]                   tempo_mode,
    output logic                         beep
);

    localparam int unsigned IDX_W   = $clog2(NUM_SONGS);
    localparam int unsigned ACT_W   = IDX_W + 1;
    localparam int unsigned ONES_W  = $clog2(NUM_SONGS + 1);
    localparam int unsigned DIV0    = CLK_HZ / TEMPO0_HZ;
    localparam int unsigned DIV1    = CLK_HZ / TEMPO1_HZ;
    localparam int unsigned DIV2    = CLK_HZ / TEMPO2_HZ;
    localparam int unsigned MAX_01  = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int unsigned MAX_DIV = (MAX_01 > DIV2) ? MAX_01 : DIV2;
    localparam int unsigned CNT_W   = $clog2(MAX_DIV);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

    // Reject configurations the divider or decoder cannot represent.
    if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2) begin : g_bad_div
        $error("song_player_ctrl: every tempo divisor must be >= 2");
    end
    if (NUM_SONGS < 2 || NUM_SONGS > 8) begin : g_bad_songs
        $error("song_player_ctrl: NUM_SONGS must be in 2..8");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("song_player_ctrl: DEBOUNCE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_FAST   = 2'd1,
        ST_SLOW   = 2'd2,
        ST_PAUSE  = 2'd3
    } tempo_e;

    logic [NUM_SONGS-1:0] key_s1_q, key_s2_q;
    logic                 sel_s1_q, sel_s2_q;
    logic                 sel_stable_q, sel_stable_d;
    logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
    logic                 press_c;
    tempo_e               state_q, state_d;
    logic [ACT_W-1:0]     active_q, active_d;
    logic                 restart_q, restart_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     div_m1_c;
    logic                 tick_q, tick_d;
    logic                 beep_q, beep_d;
    logic [ONES_W-1:0]    ones_c;
    logic [IDX_W-1:0]     idx_c;
    logic                 key_valid_c;
    logic                 beep_sel_c;

    // Two-flop synchronisers; select idles high (released).
    always_ff @(posedge clk_5MHz or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q <= '0;
            key_s2_q <= '0;
            sel_s1_q <= 1'b1;
            sel_s2_q <= 1'b1;
        end else begin
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
            sel_s1_q <= select;
            sel_s2_q <= sel_s1_q;
        end
    end

    // Debouncer: the stable level follows only after a full run of disagreement.
    always_comb begin
        sel_stable_d = sel_stable_q;
        db_cnt_d     = '0;
        if (sel_s2_q != sel_stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                sel_stable_d = sel_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    assign press_c = sel_stable_q & ~sel_stable_d;

    // Tempo FSM, stepped once per accepted press.
    always_comb begin
        state_d = state_q;
        if (press_c) begin
            case (state_q)
                ST_NORMAL: state_d = ST_FAST;
                ST_FAST:   state_d = ST_SLOW;
                ST_SLOW:   state_d = ST_PAUSE;
                default:   state_d = ST_NORMAL;
            endcase
        end
    end

    // One-hot validation and index extraction of the synced key.
    always_comb begin
        ones_c = '0;
        idx_c  = '0;
        for (int unsigned i = 0; i < NUM_SONGS; i++) begin
            if (key_s2_q[i]) begin
                ones_c = ones_c + ONES_W'(1);
                idx_c  = IDX_W'(i);
            end
        end
        key_valid_c = (ones_c == ONES_W'(1));
        active_d    = key_valid_c ? {1'b1, idx_c} : '0;
        restart_d   = (active_d != active_q);
    end

    // Beat divider; restarts a full period on any tempo or song change.
    always_comb begin
        case (state_q)
            ST_NORMAL: div_m1_c = CNT_W'(DIV0 - 1);
            ST_FAST:   div_m1_c = CNT_W'(DIV1 - 1);
            ST_SLOW:   div_m1_c = CNT_W'(DIV2 - 1);
            default:   div_m1_c = '0;
        endcase
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if ((state_d != state_q) || restart_d || (state_q == ST_PAUSE)) begin
            cnt_d = '0;
        end else if (cnt_q == div_m1_c) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Buzzer mux; silenced while invalid, paused, or entering pause.
    always_comb begin
        beep_sel_c = 1'b0;
        for (int unsigned i = 0; i < NUM_SONGS; i++) begin
            if (active_q[IDX_W-1:0] == IDX_W'(i)) begin
                beep_sel_c = song_beep[i];
            end
        end
        beep_d = 1'b0;
        if (active_q[ACT_W-1] && (state_q != ST_PAUSE) && (state_d != ST_PAUSE)) begin
            beep_d = beep_sel_c;
        end
    end

    always_ff @(posedge clk_5MHz or negedge rst_n) begin
        if (!rst_n) begin
            sel_stable_q <= 1'b1;
            db_cnt_q     <= '0;
            state_q      <= ST_NORMAL;
            active_q     <= '0;
            restart_q    <= 1'b0;
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            beep_q       <= 1'b0;
        end else begin
            sel_stable_q <= sel_stable_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            active_q     <= active_d;
            restart_q    <= restart_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            beep_q       <= beep_d;
        end
    end

    assign beat_tick    = tick_q;
    assign song_restart = restart_q;
    assign active_song  = active_q;
    assign tempo_mode   = state_q;
    assign beep         = beep_q;

endmodule

// File: tb/tb_song_player_ctrl.sv
// Directed bench for song_player_ctrl: vector table for song/tempo/debounce
// behaviour plus hand sequences for reset, restart timing and beat spacing.
module tb_song_player_ctrl;

    logic       clk_5MHz = 1'b0;
    logic       rst_n;
    logic [2:0] key;
    logic       select;
    logic [2:0] song_beep;
    logic       beat_tick;
    logic       song_restart;
    logic [2:0] active_song;
    logic [1:0] tempo_mode;
    logic       beep;

    int n_checks = 0;
    int n_pass   = 0;

    song_player_ctrl #(
        .CLK_HZ         (100),
        .NUM_SONGS      (3),
        .TEMPO0_HZ      (4),
        .TEMPO1_HZ      (5),
        .TEMPO2_HZ      (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_5MHz    (clk_5MHz),
        .rst_n       (rst_n),
        .key         (key),
        .select      (select),
        .song_beep   (song_beep),
        .beat_tick   (beat_tick),
        .song_restart(song_restart),
        .active_song (active_song),
        .tempo_mode  (tempo_mode),
        .beep        (beep)
    );

    always #5 clk_5MHz = ~clk_5MHz;

    typedef struct {
        logic [2:0] key;
        logic       sel;
        logic [2:0] sbeep;
        int         hold;
        logic [2:0] exp_act;
        logic [1:0] exp_mode;
        int         exp_rst;
        logic       exp_beep;
        int         exp_gap;   // -1 skip, 0 expect no ticks, else tick spacing
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_5MHz);
        #1;
    endtask

    // Ticks at edges 25 and 50 after release, no restart, NORMAL tempo.
    task automatic check_release(input string tag);
        int first, second, rc;
        first = 0; second = 0; rc = 0;
        for (int e = 1; e <= 60; e++) begin
            step();
            if (song_restart) rc++;
            if (beat_tick) begin
                if (first == 0) first = e;
                else if (second == 0) second = e;
            end
        end
        check({tag, "_first_tick"}, first, 25);
        check({tag, "_second_tick"}, second, 50);
        check({tag, "_restarts"}, rc, 0);
        check({tag, "_mode"}, int'(tempo_mode), 0);
    endtask

    task automatic measure_gap(input string tag, input int exp);
        int g;
        bit seen;
        if (exp == 0) begin
            g = 0;
            for (int e = 0; e < 60; e++) begin
                step();
                if (beat_tick) g++;
            end
            check({tag, "_ticks_paused"}, g, 0);
        end else begin
            seen = 0;
            for (int e = 0; e < 120 && !seen; e++) begin
                step();
                if (beat_tick) seen = 1;
            end
            g = 0;
            if (seen) begin
                for (int e = 0; e < 120; e++) begin
                    step();
                    g++;
                    if (beat_tick) break;
                end
                if (!beat_tick) g = 0;
            end
            check({tag, "_gap"}, g, exp);
        end
    endtask

    initial begin
        int r, t, rc, act_at;
        string nm;

        //           key     sel   sbeep  hold act     mode  rst beep gap
        vecs[0]  = '{3'b010, 1'b1, 3'b010, 1,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[1]  = '{3'b010, 1'b1, 3'b101, 1,  3'b101, 2'd0, 0, 1'b0, -1};
        vecs[2]  = '{3'b010, 1'b1, 3'b111, 2,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[3]  = '{3'b010, 1'b0, 3'b010, 10, 3'b101, 2'd1, 0, 1'b1, -1};
        vecs[4]  = '{3'b010, 1'b1, 3'b010, 8,  3'b101, 2'd1, 0, 1'b1, 20};
        vecs[5]  = '{3'b010, 1'b0, 3'b010, 6,  3'b101, 2'd2, 0, 1'b1, -1};
        vecs[6]  = '{3'b010, 1'b1, 3'b010, 6,  3'b101, 2'd2, 0, 1'b1, 50};
        vecs[7]  = '{3'b010, 1'b0, 3'b010, 6,  3'b101, 2'd3, 0, 1'b0, -1};
        vecs[8]  = '{3'b010, 1'b1, 3'b010, 6,  3'b101, 2'd3, 0, 1'b0, 0};
        vecs[9]  = '{3'b010, 1'b0, 3'b010, 7,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[10] = '{3'b010, 1'b1, 3'b010, 6,  3'b101, 2'd0, 0, 1'b1, 25};
        vecs[11] = '{3'b010, 1'b0, 3'b010, 2,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[12] = '{3'b010, 1'b1, 3'b010, 2,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[13] = '{3'b010, 1'b0, 3'b010, 2,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[14] = '{3'b010, 1'b1, 3'b010, 2,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[15] = '{3'b010, 1'b0, 3'b010, 2,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[16] = '{3'b010, 1'b1, 3'b010, 8,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[17] = '{3'b010, 1'b0, 3'b010, 3,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[18] = '{3'b010, 1'b1, 3'b010, 6,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[19] = '{3'b010, 1'b0, 3'b010, 4,  3'b101, 2'd0, 0, 1'b1, -1};
        vecs[20] = '{3'b010, 1'b1, 3'b010, 6,  3'b101, 2'd1, 0, 1'b1, -1};
        vecs[21] = '{3'b011, 1'b1, 3'b010, 5,  3'b000, 2'd1, 1, 1'b0, -1};
        vecs[22] = '{3'b000, 1'b1, 3'b010, 5,  3'b000, 2'd1, 0, 1'b0, -1};
        vecs[23] = '{3'b100, 1'b1, 3'b100, 5,  3'b110, 2'd1, 1, 1'b1, -1};

        rst_n = 1'b0; key = 3'b000; select = 1'b1; song_beep = 3'b000;
        repeat (3) step();
        check("rst_tick", int'(beat_tick), 0);
        check("rst_restart", int'(song_restart), 0);
        check("rst_active", int'(active_song), 0);
        check("rst_mode", int'(tempo_mode), 0);
        check("rst_beep", int'(beep), 0);

        rst_n = 1'b1;
        check_release("init");

        // Song select: restart three edges after the pin, then a full period.
        key = 3'b010;
        r = 0; act_at = 0;
        for (int e = 1; e <= 10 && r == 0; e++) begin
            step();
            if (song_restart) begin
                r = e;
                act_at = int'(active_song);
            end
        end
        check("sel_restart_edge", r, 3);
        check("sel_active_at_restart", act_at, 5);
        t = 0; rc = 0;
        for (int e = 1; e <= 60 && t == 0; e++) begin
            step();
            if (song_restart) rc++;
            if (beat_tick) t = e;
        end
        check("sel_tick_after_restart", t, 25);
        check("sel_single_restart", rc, 0);

        for (int i = 0; i < NV; i++) begin
            key = vecs[i].key;
            select = vecs[i].sel;
            song_beep = vecs[i].sbeep;
            rc = 0;
            for (int c = 0; c < vecs[i].hold; c++) begin
                step();
                if (song_restart) rc++;
            end
            nm = $sformatf("vec%0d", i);
            check({nm, "_active"}, int'(active_song), int'(vecs[i].exp_act));
            check({nm, "_mode"}, int'(tempo_mode), int'(vecs[i].exp_mode));
            check({nm, "_restarts"}, rc, vecs[i].exp_rst);
            check({nm, "_beep"}, int'(beep), int'(vecs[i].exp_beep));
            if (vecs[i].exp_gap >= 0) measure_gap(nm, vecs[i].exp_gap);
        end

        // Mid-period async reset while FAST with song 2 playing.
        repeat (7) step();
        rst_n = 1'b0; key = 3'b000; song_beep = 3'b000;
        #2;
        check("async_rst_active", int'(active_song), 0);
        check("async_rst_mode", int'(tempo_mode), 0);
        check("async_rst_beep", int'(beep), 0);
        check("async_rst_tick", int'(beat_tick), 0);
        check("async_rst_restart", int'(song_restart), 0);
        step();
        rst_n = 1'b1;
        check_release("rerelease");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
